// File: rtl/ov7670_powerup_seq.sv
// OV7670 power-up sequencer: timed PWDN -> RST -> SETTLE -> START -> WAIT -> READY.
// Optional configuration watchdog with bounded retries is built when SEQ_WATCHDOG_EN is defined.
module ov7670_powerup_seq #(
    parameter int PWDN_CYCLES   = 1_000_000,
    parameter int RST_CYCLES    = 100_000,
    parameter int SETTLE_CYCLES = 100_000,
    parameter int XCLK_DIV      = 4,
    parameter int WDT_CYCLES    = 5_000_000,
    parameter int MAX_RETRY     = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cfg_done,
    output logic o_pwdn,
    output logic o_cam_rstn,
    output logic o_xclk,
    output logic o_cfg_start,
    output logic o_ready,
    output logic o_fault
);

    localparam int MAX_PR  = (PWDN_CYCLES > RST_CYCLES) ? PWDN_CYCLES : RST_CYCLES;
    localparam int MAX_SW  = (SETTLE_CYCLES > WDT_CYCLES) ? SETTLE_CYCLES : WDT_CYCLES;
    localparam int CNT_MAX = (MAX_PR > MAX_SW) ? MAX_PR : MAX_SW;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int HALF    = XCLK_DIV / 2;
    localparam int DIV_W   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {
        S_PWDN   = 3'd0,
        S_RST    = 3'd1,
        S_SETTLE = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_READY  = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
`ifdef SEQ_WATCHDOG_EN
    logic [3:0]       r_retry;
`endif

    if ((XCLK_DIV < 2) || ((XCLK_DIV % 2) != 0) || (MAX_RETRY < 0) || (MAX_RETRY > 15)) begin : g_bad_param
        $error("ov7670_powerup_seq: illegal XCLK_DIV or MAX_RETRY");
    end

    // Sequencer state, duration counter, xclk divider and all registered outputs.
    // Outputs are updated on the same edge as the state so they always match it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_PWDN;
            r_cnt       <= '0;
            r_div       <= '0;
`ifdef SEQ_WATCHDOG_EN
            r_retry     <= 4'd0;
`endif
            o_pwdn      <= 1'b1;
            o_cam_rstn  <= 1'b0;
            o_xclk      <= 1'b0;
            o_cfg_start <= 1'b0;
            o_ready     <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            o_cfg_start <= 1'b0;

            if (r_state != S_PWDN) begin
                if (r_div == DIV_W'(HALF - 1)) begin
                    r_div  <= '0;
                    o_xclk <= ~o_xclk;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            case (r_state)
                // The cycle right after reset release already counts, hence == P rather than P-1.
                S_PWDN: begin
                    if (r_cnt == CNT_W'(PWDN_CYCLES)) begin
                        r_state <= S_RST;
                        r_cnt   <= '0;
                        r_div   <= '0;
                        o_xclk  <= 1'b0;
                        o_pwdn  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RST: begin
                    if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                        r_state    <= S_SETTLE;
                        r_cnt      <= '0;
                        o_cam_rstn <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        r_state     <= S_START;
                        r_cnt       <= '0;
                        o_cfg_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (i_cfg_done) begin
                        r_state <= S_READY;
                        o_ready <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
                    end else if (r_cnt == CNT_W'(WDT_CYCLES - 1)) begin
                        r_cnt <= '0;
                        if (r_retry < 4'(MAX_RETRY)) begin
                            r_retry    <= r_retry + 4'd1;
                            r_state    <= S_RST;
                            r_div      <= '0;
                            o_xclk     <= 1'b0;
                            o_cam_rstn <= 1'b0;
                        end else begin
                            r_state    <= S_FAULT;
                            o_fault    <= 1'b1;
                            o_cam_rstn <= 1'b0;
                            o_pwdn     <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`else
                    end else begin
                        r_state <= S_WAIT;
                    end
`endif
                end
                S_READY: begin
                    r_state <= S_READY;
                end
`ifdef SEQ_WATCHDOG_EN
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
`endif
                default: begin
                    r_state    <= S_PWDN;
                    r_cnt      <= '0;
                    o_pwdn     <= 1'b1;
                    o_cam_rstn <= 1'b0;
                    o_xclk     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_powerup_seq.sv
// Self-checking bench for ov7670_powerup_seq: directed scenarios plus randomized cfg_done/reset,
// checked every cycle against a phase-arithmetic reference model.
module tb_ov7670_powerup_seq;

    localparam int P   = 8;
    localparam int R   = 4;
    localparam int S   = 6;
    localparam int DIV = 4;
    localparam int H   = DIV / 2;
    localparam int WDT = 20;
    localparam int MXR = 2;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_done = 1'b0;
    logic pwdn, cam_rstn, xclk, cfg_start, ready, fault;

    ov7670_powerup_seq #(
        .PWDN_CYCLES(P), .RST_CYCLES(R), .SETTLE_CYCLES(S),
        .XCLK_DIV(DIV), .WDT_CYCLES(WDT), .MAX_RETRY(MXR)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cfg_done(cfg_done),
        .o_pwdn(pwdn), .o_cam_rstn(cam_rstn), .o_xclk(xclk),
        .o_cfg_start(cfg_start), .o_ready(ready), .o_fault(fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: cycle index since release, start cycle of current reset attempt
    int n, m_base, m_retry;
    bit m_ready, m_fault;
    // stimulus policy
    int done_from, done_to;
    bit noise_en;
    // observation trackers
    int starts[$];
    int rstn_falls[$];
    int first_ready, first_xclk, first_pwdn_low, first_rstn_high, first_fault;
    logic prev_xclk, prev_rstn;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pwdn"}, pwdn, 1'b1);
        chk({tag, ".cam_rstn"}, cam_rstn, 1'b0);
        chk({tag, ".xclk"}, xclk, 1'b0);
        chk({tag, ".cfg_start"}, cfg_start, 1'b0);
        chk({tag, ".ready"}, ready, 1'b0);
        chk({tag, ".fault"}, fault, 1'b0);
    endtask

    task automatic model_reset();
        n = 0; m_base = P; m_retry = 0; m_ready = 1'b0; m_fault = 1'b0;
        starts.delete(); rstn_falls.delete();
        first_ready = -1; first_xclk = -1; first_pwdn_low = -1;
        first_rstn_high = -1; first_fault = -1;
        prev_xclk = 1'b0; prev_rstn = 1'b0;
    endtask

    // Assert rst now (caller is at a negedge), check async values, release after the next posedge.
    task automatic do_reset();
        rst = 1'b1;
        cfg_done = 1'b0;
        #1 chk_reset_vals("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_hold");
        model_reset();
    endtask

    task automatic check_cycle();
        logic e_pwdn, e_rstn, e_xclk, e_start, e_ready, e_fault;
        int k;
        k = n - m_base;
        e_xclk = (n >= P) ? (((k / H) % 2) == 1) : 1'b0;
        e_start = 1'b0; e_ready = 1'b0; e_fault = 1'b0;
        if (m_fault) begin
            e_pwdn = 1'b1; e_rstn = 1'b0; e_fault = 1'b1;
        end else if (m_ready) begin
            e_pwdn = 1'b0; e_rstn = 1'b1; e_ready = 1'b1;
        end else if (n < P) begin
            e_pwdn = 1'b1; e_rstn = 1'b0;
        end else begin
            e_pwdn = 1'b0;
            e_rstn = (k >= R);
            e_start = (k == R + S);
        end
        chk("pwdn", pwdn, e_pwdn);
        chk("cam_rstn", cam_rstn, e_rstn);
        chk("xclk", xclk, e_xclk);
        chk("cfg_start", cfg_start, e_start);
        chk("ready", ready, e_ready);
        chk("fault", fault, e_fault);
        if (cfg_start === 1'b1) starts.push_back(n);
        if (prev_rstn === 1'b1 && cam_rstn === 1'b0) rstn_falls.push_back(n);
        if (ready === 1'b1 && first_ready < 0) first_ready = n;
        if (fault === 1'b1 && first_fault < 0) first_fault = n;
        if (xclk === 1'b1 && prev_xclk === 1'b0 && first_xclk < 0) first_xclk = n;
        if (pwdn === 1'b0 && first_pwdn_low < 0) first_pwdn_low = n;
        if (cam_rstn === 1'b1 && first_rstn_high < 0) first_rstn_high = n;
        prev_xclk = xclk;
        prev_rstn = cam_rstn;
    endtask

    // Move the model from cycle n to n+1 given cfg_done as driven during cycle n.
    task automatic model_advance(input logic d);
        if (!m_ready && !m_fault && n >= P && (n - m_base) > R + S) begin
            if (d) begin
                m_ready = 1'b1;
            end else if (WD && (n - m_base - R - S - 1) == WDT - 1) begin
                if (m_retry < MXR) begin
                    m_retry++;
                    m_base = n + 1;
                end else begin
                    m_fault = 1'b1;
                end
            end
        end
        n++;
    endtask

    task automatic run_cycles(input int cnt);
        logic d;
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle();
            d = (n >= done_from && n < done_to);
            if (noise_en && n < P + R + S + 1 && $urandom_range(0, 1) == 1) d = 1'b1;
            cfg_done = d;
            model_advance(d);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        do_reset();

        // nominal bring-up, then cfg_done dropped to show ready is sticky
        done_from = 25; done_to = 30; noise_en = 1'b0;
        run_cycles(45);
        chk_int("nom_pwdn_fall", first_pwdn_low, 8);
        chk_int("nom_xclk_rise", first_xclk, 10);
        chk_int("nom_rstn_rise", first_rstn_high, 12);
        chk_int("nom_start_cnt", starts.size(), 1);
        chk_int("nom_start_cyc", (starts.size() > 0) ? starts[0] : -1, 18);
        chk_int("nom_ready_cyc", first_ready, 26);

        // reset out of READY, then reset mid-sequence at cycle 14
        do_reset();
        done_from = 25; done_to = 1000;
        run_cycles(15);
        do_reset();
        run_cycles(30);
        chk_int("restart_start_cyc", (starts.size() > 0) ? starts[0] : -1, 18);
        chk_int("restart_ready_cyc", first_ready, 26);

        // cfg_done high from release: ignored until S_WAIT
        do_reset();
        done_from = 0; done_to = 1000;
        run_cycles(25);
        chk_int("early_start_cyc", (starts.size() > 0) ? starts[0] : -1, 18);
        chk_int("early_ready_cyc", first_ready, 20);

        // cfg_done never raised
        do_reset();
        done_from = 100000; done_to = 100000;
        run_cycles(110);
`ifdef SEQ_WATCHDOG_EN
        chk_int("wdt_start_cnt", starts.size(), 3);
        chk_int("wdt_start1", (starts.size() > 1) ? starts[1] : -1, 49);
        chk_int("wdt_start2", (starts.size() > 2) ? starts[2] : -1, 80);
        chk_int("wdt_rstn_fall0", (rstn_falls.size() > 0) ? rstn_falls[0] : -1, 39);
        chk_int("wdt_rstn_fall1", (rstn_falls.size() > 1) ? rstn_falls[1] : -1, 70);
        chk_int("wdt_fault_cyc", first_fault, 101);

        // cfg_done arrives on the expiry cycle
        do_reset();
        done_from = 38; done_to = 100000;
        run_cycles(50);
        chk_int("tie_ready_cyc", first_ready, 39);
        chk_int("tie_fault_cyc", first_fault, -1);
        chk_int("tie_start_cnt", starts.size(), 1);
`else
        chk_int("nowdt_start_cnt", starts.size(), 1);
        chk_int("nowdt_fault_cyc", first_fault, -1);
`endif

        // randomized cfg_done windows, pre-WAIT noise and random reset points
        for (int it = 0; it < 8; it++) begin
            do_reset();
            done_from = $urandom_range(0, 110);
            done_to = done_from + $urandom_range(1, 40);
            noise_en = 1'b1;
            run_cycles($urandom_range(5, 120));
        end
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ov7670_powerup_seq.md
# ov7670_powerup_seq

Power-up and bring-up sequencer for the OV7670 camera, sitting directly upstream of the SCCB configuration stage. Drives the camera's `pwdn`, `cam_rstn` and `xclk` pins through a timed power-down, reset and settle sequence, then issues a one-cycle start pulse to the SCCB register configurator. Reports `ready` once the configurator signals completion. An optional watchdog re-runs the reset sequence if configuration never completes.

## Interface
- `PWDN_CYCLES`, 1_000_000: clk cycles `pwdn` is held high after reset release; ≥1.
- `RST_CYCLES`, 100_000: clk cycles `cam_rstn` is held low with `xclk` running; ≥1.
- `SETTLE_CYCLES`, 100_000: clk cycles between `cam_rstn` release and `cfg_start`; ≥1.
- `XCLK_DIV`, 4: clk-to-`xclk` divide ratio; even, ≥2.
- `WDT_CYCLES`, 5_000_000: watchdog timeout in S_WAIT, in clk cycles; ≥1. Used only with `SEQ_WATCHDOG_EN`.
- `MAX_RETRY`, 3: number of reset retries before `fault`; 0..15. Used only with `SEQ_WATCHDOG_EN`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_done` in 1: level from the SCCB configurator, high when register load has finished.
- `pwdn` out 1: camera power-down, active high.
- `cam_rstn` out 1: camera reset, active low.
- `xclk` out 1: camera master clock, registered divider output.
- `cfg_start` out 1: single-cycle pulse that starts the configurator.
- `ready` out 1: sticky; high once configuration has completed.
- `fault` out 1: sticky; high once retries are exhausted. Tied 0 without the macro.

## Operation
- All outputs are registered. Reset values: `pwdn`=1, `cam_rstn`=0, `xclk`=0, `cfg_start`=0, `ready`=0, `fault`=0. State is S_PWDN, and the counter and retry count are 0.
- S_PWDN:
  - `pwdn`=1, `cam_rstn`=0, `xclk` held 0.
  - Lasts exactly PWDN_CYCLES cycles, then goes to S_RST.
- S_RST:
  - `pwdn`=0, `cam_rstn`=0, `xclk` running.
  - Lasts RST_CYCLES cycles, then goes to S_SETTLE.
- S_SETTLE:
  - `cam_rstn`=1.
  - Lasts SETTLE_CYCLES cycles, then goes to S_START.
- S_START:
  - `cfg_start`=1 for exactly one cycle, then goes to S_WAIT.
- S_WAIT:
  - `cfg_done` is sampled every cycle.
  - When it is seen high, the next state is S_READY. A `cfg_done` already high on S_WAIT entry counts.
- S_READY:
  - Terminal state. `ready`=1 and stays 1 until `rst`, even if `cfg_done` later drops.
- `cfg_done` is ignored in every state except S_WAIT.
- xclk divider:
  - A free counter toggles `xclk` every XCLK_DIV/2 clk cycles in every state except S_PWDN.
  - The counter is cleared on entry to S_RST, so the first `xclk` rising edge occurs XCLK_DIV/2 cycles into S_RST.
  - Duty cycle is 50%.
- Counters:
  - The state-duration counter is wide enough for the largest of PWDN_CYCLES, RST_CYCLES, SETTLE_CYCLES and WDT_CYCLES.
  - It is loaded on each state entry and never wraps.
- Reset mid-operation: asserting `rst` forces the reset values immediately (asynchronously) from any state, including S_READY and S_FAULT.

## Timing
- Cycle 0 is the first rising clk edge with `rst` low. The full sequence is:
  - `pwdn`=1 on cycles 0..P-1.
  - S_RST on cycles P..P+R-1.
  - S_SETTLE on cycles P+R..P+R+S-1.
  - `cfg_start` high on cycle P+R+S.
  - S_WAIT from cycle P+R+S+1.
- Latency from `cfg_done` to `ready`: if `cfg_done` is high in S_WAIT cycle n, `ready` is high from cycle n+1.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - S_WAIT counts cycles. After WDT_CYCLES cycles without `cfg_done`, the watchdog has expired.
  - On expiry with retry count < MAX_RETRY: increment the retry count and go to S_RST. `cam_rstn` drops the next cycle and the full RST → SETTLE → START sequence repeats.
  - On expiry with retry count = MAX_RETRY: go to S_FAULT. S_FAULT holds `fault`=1, `cam_rstn`=0, `pwdn`=1, and keeps `xclk` running until `rst`.
  - If `cfg_done` and expiry occur in the same cycle, `cfg_done` wins and the next state is S_READY.
- `SEQ_WATCHDOG_EN` undefined:
  - S_WAIT waits indefinitely.
  - No retry or S_FAULT logic is built, and `fault` is constant 0.

## Test plan
Common parameters: P=8, R=4, S=6, XCLK_DIV=4, WDT_CYCLES=20, MAX_RETRY=2.
- Nominal: release `rst`, raise `cfg_done` at cycle 25.
  - `pwdn` falls at cycle 8, `cam_rstn` rises at cycle 12, `cfg_start` pulses only at cycle 18, `ready`=1 from cycle 26.
  - `xclk` first rises at cycle 10, with period 4.
- Early done: `cfg_done` held high from reset release.
  - `cfg_start` pulses at cycle 18 and `ready`=1 at cycle 20.
  - `ready` is unaffected by `cfg_done` before S_WAIT.
- Reset mid-sequence: assert `rst` at cycle 14 for half a cycle.
  - Outputs immediately return to `pwdn`=1, `cam_rstn`=0, `xclk`=0.
  - The sequence restarts from cycle 0 timing.
- Sticky ready: after `ready`, drop `cfg_done`. `ready` stays 1, `cam_rstn` stays 1, and no further `cfg_start` pulse occurs.
- Watchdog (with `SEQ_WATCHDOG_EN`), `cfg_done` never raised:
  - `cfg_start` pulses at cycles 18, 49 and 80.
  - `cam_rstn` goes low at cycles 39 and 70.
  - `fault`=1 from cycle 101, with `pwdn`=1.
- Watchdog tie (with `SEQ_WATCHDOG_EN`): `cfg_done` first raised at cycle 38, the expiry cycle. `ready`=1 at cycle 39, `fault`=0, and no retry occurs.
